// File: rtl/example_pkg.sv
// Shared types and helpers for the round-robin front end of the example datapath.
package example_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int NUM_REQ_D   = 4;
    localparam int MAX_BURST_D = 4;
    localparam int MAX_REQ     = 8;

    // Wide enough for the largest supported requester count; callers cast down.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/example_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick
    import example_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_D,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    int            c;
    logic [IW-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        c    = 0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cand = IW'(c);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/example_arbiter.sv
// Round-robin arbiter sharing the example datapath's a/b inputs between requesters,
// with bounded bursts and one settle cycle between them.
module example_arbiter
    import example_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_D,
    parameter  int MAX_BURST = MAX_BURST_D,
    parameter  int CW        = 4,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] a_in,
    input  logic [NUM_REQ-1:0] b_in,
    input  logic [NUM_REQ-1:0] last,
    output logic [NUM_REQ-1:0] gnt,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic [CW-1:0]      beat
);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic [CW-1:0]      beat_q, beat_d;
    logic               last_q, last_d;

    logic               pick_any;
    logic [IW-1:0]      pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // ptr_q doubles as the current winner while in GRANT, since it moves only at grant.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        beat_d  = '0;
        last_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    ptr_d   = pick_idx;
                    gnt_d   = NUM_REQ'(onehot(3'(pick_idx)));
                    a_d     = a_in[pick_idx];
                    b_d     = b_in[pick_idx];
                    beat_d  = CW'(1);
                    last_d  = last[pick_idx];
                end
            end
            GRANT: begin
                // last_q marks that the beat already on the outputs was the final one.
                if (!req[ptr_q] || last_q || (beat_q == CW'(MAX_BURST))) begin
                    state_d = SETTLE;
                end else begin
                    gnt_d  = gnt_q;
                    a_d    = a_in[ptr_q];
                    b_d    = b_in[ptr_q];
                    beat_d = beat_q + CW'(1);
                    last_d = last[ptr_q];
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NUM_REQ - 1);
            gnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            beat_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign a    = a_q;
    assign b    = b_q;
    assign beat = beat_q;
    assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_example_arbiter.sv
// Randomized and directed bench for example_arbiter against a burst-level reference model.
module tb_example_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, a_in, b_in, last;
    logic [N-1:0]  gnt;
    logic          a, b, busy;
    logic [CW-1:0] beat;

    example_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB),
        .CW        (CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a_in (a_in),
        .b_in (b_in),
        .last (last),
        .gnt  (gnt),
        .a    (a),
        .b    (b),
        .busy (busy),
        .beat (beat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the bus, how many beats it has had, whether we are in the gap.
    int m_owner;
    int m_ptr;
    int m_beat;
    bit m_settle;
    bit m_final;
    bit m_a, m_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_owner  = -1;
            m_settle = 1'b0;
            m_ptr    = N - 1;
            m_beat   = 0;
            m_final  = 1'b0;
            m_a      = 1'b0;
            m_b      = 1'b0;
        end else if (m_settle) begin
            m_settle = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int cnd;
                cnd = (m_ptr + k) % N;
                if (m_owner < 0 && req[cnd]) begin
                    m_owner = cnd;
                    m_ptr   = cnd;
                    m_beat  = 1;
                    m_a     = a_in[cnd];
                    m_b     = b_in[cnd];
                    m_final = last[cnd];
                end
            end
        end else if (!req[m_owner] || m_final || m_beat == MB) begin
            m_owner  = -1;
            m_settle = 1'b1;
            m_beat   = 0;
            m_final  = 1'b0;
        end else begin
            m_beat  = m_beat + 1;
            m_a     = a_in[m_owner];
            m_b     = b_in[m_owner];
            m_final = last[m_owner];
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("a", 32'(a), (m_owner >= 0) ? 32'(m_a) : 32'd0);
        chk("b", 32'(b), (m_owner >= 0) ? 32'(m_b) : 32'd0);
        chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("beat", 32'(beat), 32'(m_beat));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("zero_ab", (gnt == '0) ? 32'({a, b}) : 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        last = '0;
        step();
        rst  = 1'b0;
    endtask

    logic [N-1:0] order[$];
    logic [N-1:0] pg;
    int           hits;

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        last = '0;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;

        // Lone requester: 4-beat bursts, re-granted every MB+2 cycles.
        req  = 4'b0001;
        a_in = 4'b0001;
        b_in = 4'b0001;
        repeat (14) step();

        // All requesters active: rotation 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        order.delete();
        for (int i = 0; i < 40; i++) begin
            pg   = gnt;
            a_in = N'($urandom);
            b_in = N'($urandom);
            step();
            if (pg == '0 && gnt != '0) order.push_back(gnt);
        end
        chk("rr_count", 32'(order.size() >= 5), 32'd1);
        if (order.size() >= 5) begin
            chk("rr_0", 32'(order[0]), 32'b0001);
            chk("rr_1", 32'(order[1]), 32'b0010);
            chk("rr_2", 32'(order[2]), 32'b0100);
            chk("rr_3", 32'(order[3]), 32'b1000);
            chk("rr_4", 32'(order[4]), 32'b0001);
        end

        // last on the second beat ends the burst after two beats.
        do_reset();
        req  = 4'b0100;
        step();
        last = 4'b0100;
        step();
        chk("last_beat2", 32'(beat), 32'd2);
        last = '0;
        step();
        chk("last_end", 32'(gnt), 32'd0);
        req = '0;
        repeat (3) step();

        // Requester 1 drops after its first beat; pending requester 3 follows.
        do_reset();
        req = 4'b1010;
        step();
        chk("drop_gnt1", 32'(gnt), 32'b0010);
        req = 4'b1000;
        step();
        chk("drop_gnt0", 32'(gnt), 32'd0);
        step();
        step();
        chk("pend_gnt3", 32'(gnt), 32'b1000);
        req = '0;
        repeat (6) step();

        // Reset mid-burst, then pointer restarts at requester 0.
        do_reset();
        req = 4'b0001;
        step();
        step();
        chk("pre_rst_beat", 32'(beat), 32'd2);
        rst = 1'b1;
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_beat", 32'(beat), 32'd0);
        rst = 1'b0;
        req = 4'b1000;
        step();
        chk("rst_gnt3", 32'(gnt), 32'b1000);
        do_reset();
        req = 4'b1111;
        step();
        chk("rst_all_gnt0", 32'(gnt), 32'b0001);

        // Pulses only while in SETTLE must not produce a grant.
        do_reset();
        req  = 4'b0001;
        last = 4'b0001;
        step();
        req  = '0;
        last = '0;
        step();
        chk("in_settle", 32'(m_settle), 32'd1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            req = m_settle ? N'($urandom_range(1, 15)) : '0;
            step();
            if (gnt != '0) hits++;
        end
        chk("pulse_nogrant", 32'(hits), 32'd0);

        // Random traffic with occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++) begin
                if (!req[r]) req[r] = ($urandom_range(0, 3) == 0);
                else         req[r] = ($urandom_range(0, 7) != 0);
            end
            a_in = N'($urandom);
            b_in = N'($urandom);
            last = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
